// File: rtl/player_controller.sv
// Player movement/interaction: synchronised buttons -> per-frame position with collision and clamping, plus pick-up/drop pulses.
// Latency: position lands 3 cycles after IDLE takes a frame tick, pulses 1 cycle after ACT; no backpressure, late edges fold into pending flags.
module player_controller #(
  parameter int SPEED   = 2,
  parameter int SPAWN_X = 192,
  parameter int SPAWN_Y = 112,
  parameter int MAX_X   = 384,
  parameter int MAX_Y   = 224
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   btn_up,
  input  logic                   btn_down,
  input  logic                   btn_left,
  input  logic                   btn_right,
  input  logic                   btn_action,
  input  logic                   vsync_in,
  input  logic [2:0]             game_state,
  input  logic [7:0][12:0][3:0]  object_grid,
  output logic [8:0]             player_x,
  output logic [8:0]             player_y,
  output logic [1:0]             player_direction,
  output logic [3:0]             player_state,
  output logic                   pickup_valid,
  output logic                   drop_valid,
  output logic [2:0]             target_row,
  output logic [3:0]             target_col,
  output logic [3:0]             drop_item
);
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CHECK_A = 3'd1;
  localparam logic [2:0] S_CHECK_B = 3'd2;
  localparam logic [2:0] S_COMMIT  = 3'd3;
  localparam logic [2:0] S_ACT     = 3'd4;

  localparam logic [9:0] SPD   = 10'(SPEED);
  localparam logic [9:0] MAXX  = 10'(MAX_X);
  localparam logic [9:0] MAXY  = 10'(MAX_Y);
  localparam logic [8:0] SPWNX = 9'(SPAWN_X);
  localparam logic [8:0] SPWNY = 9'(SPAWN_Y);

  // bit order: {action, right, left, down, up, vsync}
  logic [5:0] s1_q, s2_q;
  logic       vs_prev_q, act_prev_q;
  logic [2:0] fsm_q, fsm_d;
  logic [8:0] x_q, x_d, y_q, y_d, nx_q, nx_d, ny_q, ny_d;
  logic [1:0] dir_q, dir_d;
  logic [3:0] held_q, held_d, drop_item_q, drop_item_d;
  logic       tick_pend_q, tick_pend_d, act_pend_q, act_pend_d;
  logic       blocked_q, blocked_d, pickup_q, pickup_d, drop_q, drop_d;
  logic [2:0] trow_q, trow_d;
  logic [3:0] tcol_q, tcol_d;

  logic       frame_tick, act_edge, any_dir;
  logic [1:0] dir_sel;
  logic [9:0] x10, y10, cand_x, cand_y, cx, cy, tx, ty;
  logic       t_out;
  logic [8:0] px, py;
  logic [2:0] lk_row;
  logic [3:0] lk_col, code;

  assign frame_tick = vs_prev_q & ~s2_q[0];
  assign act_edge   = s2_q[5] & ~act_prev_q;
  assign any_dir    = |s2_q[4:1];
  assign dir_sel    = s2_q[1] ? 2'd0 : s2_q[2] ? 2'd1 : s2_q[3] ? 2'd2 : 2'd3;
  assign x10        = {1'b0, x_q};
  assign y10        = {1'b0, y_q};

  always_comb begin
    cand_x = x10;
    cand_y = y10;
    case (dir_sel)
      2'd0:    cand_y = (y10 < SPD) ? 10'd0 : y10 - SPD;
      2'd1:    cand_y = (y10 + SPD > MAXY) ? MAXY : y10 + SPD;
      2'd2:    cand_x = (x10 < SPD) ? 10'd0 : x10 - SPD;
      default: cand_x = (x10 + SPD > MAXX) ? MAXX : x10 + SPD;
    endcase
  end

  // Leading-edge corner: CHECK_A takes the first, CHECK_B the second.
  always_comb begin
    px = ((dir_q == 2'd3) || (fsm_q == S_CHECK_B && dir_q != 2'd2)) ? nx_q + 9'd31 : nx_q;
    py = ((dir_q == 2'd1) || (fsm_q == S_CHECK_B && dir_q != 2'd0)) ? ny_q + 9'd31 : ny_q;
  end

  always_comb begin
    cx    = x10 + 10'd16;
    cy    = y10 + 10'd16;
    tx    = cx;
    ty    = cy;
    t_out = 1'b0;
    case (dir_q)
      2'd0: begin t_out = (cy < 10'd32); ty = cy - 10'd32; end
      2'd1: begin ty = cy + 10'd32; t_out = (ty > 10'd255); end
      2'd2: begin t_out = (cx < 10'd32); tx = cx - 10'd32; end
      default: begin tx = cx + 10'd32; t_out = (tx > 10'd415); end
    endcase
  end

  always_comb begin
    lk_row = (fsm_q == S_ACT) ? ty[7:5] : py[7:5];
    lk_col = (fsm_q == S_ACT) ? tx[8:5] : px[8:5];
    code   = 4'd0;
    if (lk_col < 4'd13) code = object_grid[lk_row][lk_col];
  end

  always_comb begin
    fsm_d       = fsm_q;
    x_d         = x_q;
    y_d         = y_q;
    nx_d        = nx_q;
    ny_d        = ny_q;
    dir_d       = dir_q;
    held_d      = held_q;
    drop_item_d = drop_item_q;
    tick_pend_d = tick_pend_q;
    act_pend_d  = act_pend_q;
    blocked_d   = blocked_q;
    pickup_d    = 1'b0;
    drop_d      = 1'b0;
    trow_d      = trow_q;
    tcol_d      = tcol_q;
    case (fsm_q)
      S_IDLE: begin
        if (game_state != 3'd1) begin
          x_d         = SPWNX;
          y_d         = SPWNY;
          tick_pend_d = 1'b0;
          act_pend_d  = 1'b0;
        end else if (tick_pend_q) begin
          tick_pend_d = 1'b0;
          if (any_dir) begin
            dir_d     = dir_sel;
            nx_d      = cand_x[8:0];
            ny_d      = cand_y[8:0];
            blocked_d = 1'b0;
            fsm_d     = S_CHECK_A;
          end
        end else if (act_pend_q) begin
          act_pend_d = 1'b0;
          fsm_d      = S_ACT;
        end
      end
      S_CHECK_A: begin
        blocked_d = blocked_q | (code != 4'd0);
        fsm_d     = S_CHECK_B;
      end
      S_CHECK_B: begin
        blocked_d = blocked_q | (code != 4'd0);
        fsm_d     = S_COMMIT;
      end
      S_COMMIT: begin
        if (!blocked_q) begin
          x_d = nx_q;
          y_d = ny_q;
        end
        fsm_d = S_IDLE;
      end
      S_ACT: begin
        if (!t_out) begin
          if (held_q == 4'd0 && code != 4'd0 && code < 4'd8) begin
            held_d   = code;
            pickup_d = 1'b1;
            trow_d   = lk_row;
            tcol_d   = lk_col;
          end else if (held_q != 4'd0 && code == 4'd8) begin
            drop_item_d = held_q;
            held_d      = 4'd0;
            drop_d      = 1'b1;
            trow_d      = lk_row;
            tcol_d      = lk_col;
          end
        end
        fsm_d = S_IDLE;
      end
      default: fsm_d = S_IDLE;
    endcase
    // New edges win over same-cycle consumption so none is dropped.
    if (frame_tick) tick_pend_d = 1'b1;
    if (act_edge)   act_pend_d  = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_q        <= '0;
      s2_q        <= '0;
      vs_prev_q   <= 1'b0;
      act_prev_q  <= 1'b0;
      fsm_q       <= S_IDLE;
      x_q         <= SPWNX;
      y_q         <= SPWNY;
      nx_q        <= '0;
      ny_q        <= '0;
      dir_q       <= 2'd1;
      held_q      <= '0;
      drop_item_q <= '0;
      tick_pend_q <= 1'b0;
      act_pend_q  <= 1'b0;
      blocked_q   <= 1'b0;
      pickup_q    <= 1'b0;
      drop_q      <= 1'b0;
      trow_q      <= '0;
      tcol_q      <= '0;
    end else begin
      s1_q        <= {btn_action, btn_right, btn_left, btn_down, btn_up, vsync_in};
      s2_q        <= s1_q;
      vs_prev_q   <= s2_q[0];
      act_prev_q  <= s2_q[5];
      fsm_q       <= fsm_d;
      x_q         <= x_d;
      y_q         <= y_d;
      nx_q        <= nx_d;
      ny_q        <= ny_d;
      dir_q       <= dir_d;
      held_q      <= held_d;
      drop_item_q <= drop_item_d;
      tick_pend_q <= tick_pend_d;
      act_pend_q  <= act_pend_d;
      blocked_q   <= blocked_d;
      pickup_q    <= pickup_d;
      drop_q      <= drop_d;
      trow_q      <= trow_d;
      tcol_q      <= tcol_d;
    end
  end

  assign player_x         = x_q;
  assign player_y         = y_q;
  assign player_direction = dir_q;
  assign player_state     = held_q;
  assign pickup_valid     = pickup_q;
  assign drop_valid       = drop_q;
  assign target_row       = trow_q;
  assign target_col       = tcol_q;
  assign drop_item        = drop_item_q;
endmodule

// File: tb/tb_player_controller.sv
// Directed bench for player_controller: position/direction checks inline, pulses checked against a scoreboard queue.
module tb_player_controller;
  logic                  clock = 1'b0;
  logic                  reset = 1'b0;
  logic                  btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_action = 1'b0;
  logic                  vsync_in = 1'b1;
  logic [2:0]            game_state = 3'd0;
  logic [7:0][12:0][3:0] grid;
  logic [8:0]            player_x, player_y;
  logic [1:0]            player_direction;
  logic [3:0]            player_state, drop_item, target_col;
  logic                  pickup_valid, drop_valid;
  logic [2:0]            target_row;

  typedef struct {
    logic       is_drop;
    logic [2:0] row;
    logic [3:0] col;
    logic [3:0] item;
    logic [3:0] state;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   pulses_seen = 0;
  int   pulses_pushed = 0;
  logic prev_pulse = 1'b0;

  player_controller dut (
    .clock(clock), .reset(reset),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .btn_action(btn_action), .vsync_in(vsync_in), .game_state(game_state), .object_grid(grid),
    .player_x(player_x), .player_y(player_y), .player_direction(player_direction),
    .player_state(player_state), .pickup_valid(pickup_valid), .drop_valid(drop_valid),
    .target_row(target_row), .target_col(target_col), .drop_item(drop_item)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic frame();
    vsync_in = 1'b0;
    cyc(10);
    vsync_in = 1'b1;
    cyc(10);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  task automatic set_dirs(input logic u, input logic d, input logic l, input logic r);
    btn_up = u; btn_down = d; btn_left = l; btn_right = r;
  endtask

  task automatic push_exp(input logic is_drop, input logic [2:0] row, input logic [3:0] col,
                          input logic [3:0] item, input logic [3:0] state);
    exp_t e;
    e.is_drop = is_drop; e.row = row; e.col = col; e.item = item; e.state = state;
    sb.push_back(e);
    pulses_pushed++;
  endtask

  // Bounded: the pulse must have come and gone well inside the 8 trailing cycles.
  task automatic press_action(input string tag);
    btn_action = 1'b1;
    cyc(3);
    btn_action = 1'b0;
    cyc(8);
    chk({tag, "_sb_drained"}, sb.size(), 0);
  endtask

  task automatic do_reset();
    set_dirs(0, 0, 0, 0);
    reset = 1'b0;
    cyc(2);
    reset = 1'b1;
    cyc(2);
  endtask

  always @(negedge clock) begin
    if (reset) begin
      if (pickup_valid || drop_valid) begin
        pulses_seen++;
        chk("pulse_one_cycle", prev_pulse, 0);
        chk("pulse_expected", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          mon_e = sb.pop_front();
          chk("pulse_kind_drop", drop_valid, mon_e.is_drop);
          chk("pulse_kind_pickup", pickup_valid, !mon_e.is_drop);
          chk("pulse_row", target_row, mon_e.row);
          chk("pulse_col", target_col, mon_e.col);
          chk("pulse_state", player_state, mon_e.state);
          if (mon_e.is_drop) chk("pulse_drop_item", drop_item, mon_e.item);
        end
      end
      prev_pulse = pickup_valid | drop_valid;
    end else begin
      prev_pulse = 1'b0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    grid = '0;
    cyc(3);
    chk("rst_x", player_x, 192);
    chk("rst_y", player_y, 112);
    chk("rst_dir", player_direction, 1);
    chk("rst_state", player_state, 0);
    chk("rst_pickup", pickup_valid, 0);
    chk("rst_drop", drop_valid, 0);
    chk("rst_row", target_row, 0);
    chk("rst_col", target_col, 0);
    chk("rst_drop_item", drop_item, 0);
    reset = 1'b1;
    game_state = 3'd1;
    cyc(3);

    // Ten frames moving right on an empty grid.
    set_dirs(0, 0, 0, 1);
    cyc(3);
    frames(10);
    chk("right10_x", player_x, 212);
    chk("right10_y", player_y, 112);
    chk("right10_dir", player_direction, 3);

    // Reset lands in CHECK_B: vsync falls, 5 edges later the FSM is in CHECK_B.
    vsync_in = 1'b0;
    cyc(5);
    reset = 1'b0;
    cyc(2);
    chk("midrst_x", player_x, 192);
    chk("midrst_y", player_y, 112);
    chk("midrst_dir", player_direction, 1);
    chk("midrst_pickup", pickup_valid, 0);
    chk("midrst_drop", drop_valid, 0);
    vsync_in = 1'b1;
    reset = 1'b1;
    cyc(3);

    // Run into the right play-area limit and stay clamped there.
    frames(100);
    chk("clamp_right_x", player_x, 384);
    set_dirs(0, 0, 1, 1);
    cyc(3);
    frame();
    chk("left_prio_x", player_x, 382);
    chk("left_prio_dir", player_direction, 2);
    set_dirs(0, 0, 0, 1);
    cyc(3);
    frame();
    chk("reclamp_x", player_x, 384);

    // Solid tile ahead: direction turns, position stays.
    do_reset();
    grid[3][7] = 4'd9;
    set_dirs(0, 0, 0, 1);
    cyc(3);
    frame();
    set_dirs(0, 0, 0, 0);
    chk("blocked_x", player_x, 192);
    chk("blocked_y", player_y, 112);
    chk("blocked_dir", player_direction, 3);

    // Pick up item 3 from the tile to the right, then drop it on a counter.
    grid[4][7] = 4'd3;
    push_exp(1'b0, 3'd4, 4'd7, 4'd0, 4'd3);
    press_action("pickup");
    chk("pickup_held", player_state, 3);
    chk("pickup_row_hold", target_row, 4);
    chk("pickup_col_hold", target_col, 7);

    grid[4][7] = 4'd8;
    push_exp(1'b1, 3'd4, 4'd7, 4'd3, 4'd0);
    press_action("drop");
    chk("drop_held", player_state, 0);
    chk("drop_item_hold", drop_item, 3);

    press_action("empty_on_counter");
    chk("empty_on_counter_held", player_state, 0);

    // Up beats right; then clamp at the top edge.
    grid = '0;
    set_dirs(1, 0, 0, 1);
    cyc(3);
    frame();
    chk("upright_x", player_x, 192);
    chk("upright_y", player_y, 110);
    chk("upright_dir", player_direction, 0);
    set_dirs(1, 0, 0, 0);
    frames(60);
    set_dirs(0, 0, 0, 0);
    chk("clamp_top_y", player_y, 0);
    chk("clamp_top_dir", player_direction, 0);

    // Target one tile above y=0 lies off the play area: no action.
    grid[0][6] = 4'd5;
    grid[7][6] = 4'd5;
    press_action("offgrid");
    chk("offgrid_held", player_state, 0);
    grid = '0;

    // Outside GAME the sprite sits at spawn regardless of buttons.
    game_state = 3'd0;
    set_dirs(1, 0, 0, 1);
    cyc(3);
    frames(5);
    chk("nogame_x", player_x, 192);
    chk("nogame_y", player_y, 112);
    grid[2][6] = 4'd4;
    press_action("nogame_act");
    chk("nogame_held", player_state, 0);
    set_dirs(0, 0, 0, 0);

    chk("sb_final_empty", sb.size(), 0);
    chk("pulse_count", pulses_seen, pulses_pushed);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
